// File: rtl/cacheline_adapter.sv
// Bridges one 256-bit cacheline read/write to a 4-beat 64-bit bmem burst.
// Read beats are reassembled into a line; completion is a one-cycle valid_out.
module cacheline_adapter #(
  parameter int BEAT_W    = 64,
  parameter int BURST_LEN = 4,
  parameter int LINE_W    = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read_enable,
  input  logic              write_enable,
  input  logic [31:0]       addr,
  input  logic [LINE_W-1:0] write_data,
  output logic [LINE_W-1:0] data_out,
  output logic              valid_out,
  output logic [31:0]       bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic              bmem_ready,
  input  logic [31:0]       bmem_raddr,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_rvalid
);

  localparam int CW = $clog2(BURST_LEN) + 1;
  localparam logic [CW-1:0] LAST = CW'(BURST_LEN - 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] RD_REQ   = 3'd1;
  localparam logic [2:0] RD_WAIT  = 3'd2;
  localparam logic [2:0] WR_BURST = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;
  localparam logic [2:0] COOL     = 3'd5;

  logic [2:0]        state;
  logic [CW-1:0]     cnt;
  logic [LINE_W-1:0] line_buf;
  logic [LINE_W-1:0] wdata_q;
  logic [31:0]       addr_q;
  logic              is_read;
  logic [BEAT_W-1:0] beat;

  // Offset bits of the line address are intentionally discarded.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[4:0];

  always_comb begin
    beat = '0;
    for (int unsigned i = 0; i < BURST_LEN; i++) begin
      if (cnt == CW'(i)) beat = wdata_q[i*BEAT_W +: BEAT_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      line_buf <= '0;
      wdata_q  <= '0;
      addr_q   <= '0;
      is_read  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (write_enable) begin
            addr_q  <= {addr[31:5], 5'b0};
            wdata_q <= write_data;
            is_read <= 1'b0;
            cnt     <= '0;
            state   <= WR_BURST;
          end else if (read_enable) begin
            addr_q  <= {addr[31:5], 5'b0};
            is_read <= 1'b1;
            cnt     <= '0;
            state   <= RD_REQ;
          end
        end
        RD_REQ: begin
          if (bmem_ready) begin
            cnt   <= '0;
            state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (bmem_rvalid && (bmem_raddr == addr_q)) begin
            for (int unsigned i = 0; i < BURST_LEN; i++) begin
              if (cnt == CW'(i)) line_buf[i*BEAT_W +: BEAT_W] <= bmem_rdata;
            end
            cnt <= cnt + CW'(1);
            if (cnt == LAST) state <= DONE;
          end
        end
        WR_BURST: begin
          if (bmem_ready) begin
            cnt <= cnt + CW'(1);
            if (cnt == LAST) state <= DONE;
          end
        end
        DONE:    state <= COOL;
        COOL:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    valid_out  = 1'b0;
    data_out   = '0;
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    bmem_addr  = '0;
    bmem_wdata = '0;
    case (state)
      RD_REQ: begin
        bmem_read = 1'b1;
        bmem_addr = addr_q;
      end
      WR_BURST: begin
        bmem_write = 1'b1;
        bmem_addr  = addr_q;
        bmem_wdata = beat;
      end
      DONE: begin
        valid_out = 1'b1;
        if (is_read) data_out = line_buf;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cacheline_adapter.sv
// Table-driven bench for cacheline_adapter with scoreboards for write beats
// and completed lines, plus a hand-written mid-burst reset sequence.
module tb_cacheline_adapter;

  localparam int BEAT_W    = 64;
  localparam int BURST_LEN = 4;
  localparam int LINE_W    = 256;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              read_enable = 1'b0;
  logic              write_enable = 1'b0;
  logic [31:0]       addr = '0;
  logic [LINE_W-1:0] write_data = '0;
  logic [LINE_W-1:0] data_out;
  logic              valid_out;
  logic [31:0]       bmem_addr;
  logic              bmem_read;
  logic              bmem_write;
  logic [BEAT_W-1:0] bmem_wdata;
  logic              bmem_ready = 1'b0;
  logic [31:0]       bmem_raddr = '0;
  logic [BEAT_W-1:0] bmem_rdata = '0;
  logic              bmem_rvalid = 1'b0;

  always #5 clk = ~clk;

  cacheline_adapter #(.BEAT_W(BEAT_W), .BURST_LEN(BURST_LEN), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst(rst), .read_enable(read_enable), .write_enable(write_enable),
    .addr(addr), .write_data(write_data), .data_out(data_out), .valid_out(valid_out),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
  );

  typedef struct {
    logic        wr;
    logic        both;
    logic [31:0] addr;
    logic [255:0] line;
    logic [3:0]  stall;     // write: 2-cycle stall before beat i; read: bad-tag beat before beat i
    logic        stray;
    int          done_cyc;
  } txn_t;

  typedef struct {
    logic [31:0] a;
    logic [63:0] d;
  } beat_t;

  logic [255:0] exp_line[$];
  beat_t        exp_beat[$];
  txn_t         vec[6];
  int           total = 0;
  int           bad = 0;
  logic         prev_stall = 1'b0;
  logic [63:0]  prev_wdata = '0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: event seen with nothing expected", name);
  endtask

  function automatic logic [511:0] outs();
    return {157'd0, data_out, valid_out, bmem_addr, bmem_read, bmem_write, bmem_wdata};
  endfunction

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Samples at the falling edge and runs both scoreboards.
  task automatic sample();
    beat_t b;
    @(negedge clk);
    if (rst) begin
      if (prev_stall && bmem_write) chk("beat_hold", bmem_wdata, prev_wdata);
      if (bmem_write && bmem_ready) begin
        if (exp_beat.size() == 0) fail("extra_beat");
        else begin
          b = exp_beat.pop_front();
          chk("wr_addr", bmem_addr, b.a);
          chk("wr_data", bmem_wdata, b.d);
        end
      end
      if (valid_out) begin
        if (exp_line.size() == 0) fail("extra_valid");
        else chk("line_data", data_out, exp_line.pop_front());
      end
    end
    prev_stall = bmem_write && !bmem_ready;
    prev_wdata = bmem_wdata;
  endtask

  task automatic push_write(input logic [31:0] al, input logic [255:0] line);
    beat_t b;
    for (int i = 0; i < BURST_LEN; i++) begin
      b.a = al;
      b.d = line[64*i +: 64];
      exp_beat.push_back(b);
    end
  endtask

  task automatic run_txn(input txn_t t);
    logic [31:0] al;
    int acc, scnt, beat, rdcmd;
    bit mis_done, seen;
    al = {t.addr[31:5], 5'b0};
    acc = 0; scnt = 0; beat = 0; rdcmd = 0; mis_done = 0; seen = 0;

    next();
    write_enable = t.wr;
    read_enable  = !t.wr || t.both;
    addr         = t.addr;
    write_data   = t.wr ? t.line : ~t.line;
    bmem_ready   = 1'b1;
    bmem_rvalid  = t.stray;
    bmem_raddr   = al;
    bmem_rdata   = 64'hdead_beef_0bad_f00d;
    exp_line.push_back(t.wr ? 256'd0 : t.line);
    if (t.wr) push_write(al, t.line);
    sample();
    chk("accept_quiet", {bmem_read, bmem_write, bmem_addr}, '0);

    for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
      next();
      bmem_rvalid = 1'b0;
      if (t.wr) begin
        if (acc < 4 && t.stall[acc] && scnt < 2) begin
          bmem_ready = 1'b0;
          scnt++;
        end else bmem_ready = 1'b1;
      end else begin
        bmem_ready = 1'b1;
        if (cyc == 1 && t.stray) begin
          bmem_rvalid = 1'b1;
          bmem_raddr  = al;
          bmem_rdata  = 64'hfeed_face_cafe_d00d;
        end else if (cyc >= 4 && beat < 4) begin
          bmem_rvalid = 1'b1;
          if (t.stall[beat] && !mis_done) begin
            bmem_raddr = al ^ 32'h20;
            bmem_rdata = ~t.line[64*beat +: 64];
            mis_done = 1;
          end else begin
            bmem_raddr = al;
            bmem_rdata = t.line[64*beat +: 64];
            beat++;
            mis_done = 0;
          end
        end
      end
      sample();
      if (bmem_write && bmem_ready) begin
        acc++;
        scnt = 0;
      end
      if (bmem_read) begin
        rdcmd++;
        chk("rd_addr", bmem_addr, al);
      end
      if (valid_out) begin
        seen = 1;
        chk("done_cycle", cyc, t.done_cyc);
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL timeout: got no valid_out want valid_out by cycle %0d", t.done_cyc);
    end
    if (!t.wr) chk("rd_cmd_cycles", rdcmd, 1);

    next();
    bmem_rvalid = 1'b0;
    bmem_ready  = 1'b1;
    if (!t.both) begin
      read_enable  = 1'b0;
      write_enable = 1'b0;
    end
    sample();
    chk("cool_quiet", outs(), '0);

    next();
    read_enable  = 1'b0;
    write_enable = 1'b0;
    sample();
    chk("idle_quiet", outs(), '0);
    next();
    sample();
    chk("idle_quiet2", outs(), '0);
    chk("beats_left", exp_beat.size(), 0);
    chk("lines_left", exp_line.size(), 0);
  endtask

  initial begin
    vec[0] = '{wr: 1'b0, both: 1'b0, addr: 32'h1000_0044,
               line: {64'h4444, 64'h3333, 64'h2222, 64'h1111},
               stall: 4'b0000, stray: 1'b0, done_cyc: 8};
    vec[1] = '{wr: 1'b1, both: 1'b0, addr: 32'h0000_2000,
               line: {64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
                      64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD},
               stall: 4'b0000, stray: 1'b0, done_cyc: 5};
    vec[2] = '{wr: 1'b1, both: 1'b0, addr: 32'h0000_3010,
               line: {64'h0123_4567_89ab_cdef, 64'h1357_9bdf_0246_8ace,
                      64'hfedc_ba98_7654_3210, 64'h0f0f_f0f0_5a5a_a5a5},
               stall: 4'b0110, stray: 1'b0, done_cyc: 9};
    vec[3] = '{wr: 1'b1, both: 1'b1, addr: 32'h0000_4000,
               line: {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888,
                      64'h9999_aaaa_bbbb_cccc, 64'hdddd_eeee_ffff_0000},
               stall: 4'b0000, stray: 1'b0, done_cyc: 5};
    vec[4] = '{wr: 1'b0, both: 1'b0, addr: 32'h2000_00ff,
               line: {64'hc0de_0003_c0de_0003, 64'hc0de_0002_c0de_0002,
                      64'hc0de_0001_c0de_0001, 64'hc0de_0000_c0de_0000},
               stall: 4'b0100, stray: 1'b1, done_cyc: 9};
    vec[5] = '{wr: 1'b0, both: 1'b0, addr: 32'h3000_0020,
               line: {64'h8765_4321_0000_0004, 64'h8765_4321_0000_0003,
                      64'h8765_4321_0000_0002, 64'h8765_4321_0000_0001},
               stall: 4'b0000, stray: 1'b0, done_cyc: 8};

    next();
    sample();
    chk("reset_outs", outs(), '0);
    next();
    rst = 1'b1;
    sample();
    chk("idle_outs", outs(), '0);

    for (int i = 0; i < 5; i++) run_txn(vec[i]);

    // Reset while a write burst is mid-way: two beats out, then abandon.
    next();
    write_enable = 1'b1;
    addr         = 32'h0000_5000;
    write_data   = vec[2].line;
    bmem_ready   = 1'b1;
    exp_line.push_back(256'd0);
    push_write(32'h0000_5000, vec[2].line);
    sample();
    next();
    sample();
    next();
    sample();
    next();
    bmem_ready = 1'b0;
    rst = 1'b0;
    sample();
    next();
    rst = 1'b1;
    write_enable = 1'b0;
    bmem_ready = 1'b1;
    sample();
    chk("rst_outs", outs(), '0);
    chk("rst_beats_left", exp_beat.size(), 2);
    chk("rst_lines_left", exp_line.size(), 1);
    exp_beat.delete();
    exp_line.delete();
    next();
    sample();
    chk("rst_idle", outs(), '0);
    run_txn(vec[5]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cacheline_adapter.md
Name: cacheline_adapter

Overview:
Sits between the cacheline arbiter and the burst memory model (bmem). It accepts one 256-bit cacheline read or write from the arbiter side and sequences it as a 4-beat, 64-bit burst on bmem. It reassembles read beats into a full line and returns a one-cycle valid_out for both reads and writes. One transaction is in flight at a time.

Parameters:
BEAT_W, 64, bmem data beat width
BURST_LEN, 4, beats per cacheline
LINE_W, 256, cacheline width; must equal BEAT_W*BURST_LEN

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset (rst==0 resets on posedge clk)
read_enable  in  1  line read request; held by requester until valid_out
write_enable  in  1  line write request; held by requester until valid_out
addr  in  32  line address; bits [4:0] ignored
write_data  in  LINE_W  line write data; beat i = bits [BEAT_W*i +: BEAT_W]
data_out  out  LINE_W  assembled read line; 0 on write completion
valid_out  out  1  one-cycle completion pulse, read or write
bmem_addr  out  32  burst address, {addr[31:5],5'b0}
bmem_read  out  1  read command
bmem_write  out  1  write beat valid
bmem_wdata  out  BEAT_W  write beat data
bmem_ready  in  1  bmem accepts command/beat this cycle
bmem_raddr  in  32  address tag of returning read beat
bmem_rdata  in  BEAT_W  read beat data
bmem_rvalid  in  1  read beat valid

Behaviour:
- Reset (rst==0): state=IDLE; beat counter=0; line buffer=0; every output is 0. Reset mid-burst abandons the transaction. Beats already issued to bmem are not tracked afterwards.
- States: IDLE, RD_REQ, RD_WAIT, WR_BURST, DONE, COOL.
- IDLE: if write_enable=1, latch aligned addr and write_data, then go to WR_BURST. Else if read_enable=1, latch aligned addr, then go to RD_REQ. Write wins if both are high. Acceptance registers only; no bmem output is asserted in the IDLE cycle.
- RD_REQ: drive bmem_read=1 and bmem_addr=latched addr. Hold both until the cycle bmem_ready=1, then go to RD_WAIT with counter=0.
- RD_WAIT: on bmem_rvalid=1 with bmem_raddr==latched addr, store bmem_rdata into buffer slice [counter] and increment counter.
  - Beats with a mismatched raddr are dropped.
  - The beat that makes counter==BURST_LEN moves to DONE.
- WR_BURST: drive bmem_write=1, bmem_addr=latched addr, and bmem_wdata=slice[counter] of the latched data.
  - Counter increments only on cycles where bmem_ready=1; otherwise the beat is held unchanged.
  - After the acceptance of beat BURST_LEN-1, go to DONE.
- DONE: valid_out=1 for exactly this cycle. data_out=buffer for reads, 0 for writes. Next state is COOL.
- COOL: one dead cycle with all outputs 0. Requests are ignored, which absorbs the requester's request still held from the prior cycle. Next state is IDLE.
- Outside DONE: data_out=0 and valid_out=0.
- Outside RD_REQ/WR_BURST: bmem_read=0, bmem_write=0, bmem_addr=0, bmem_wdata=0.
- bmem_rvalid outside RD_WAIT is ignored.
- Request inputs are sampled only in IDLE; changes while busy have no effect.
- Counter width is clog2(BURST_LEN)+1 and does not wrap.
- Minimum latency with bmem_ready=1 throughout:
  - Write: accept at cycle 0, beats at cycles 1–4, valid_out at cycle 5, IDLE again at cycle 7.
  - Read: valid_out comes 1 cycle after the last matching rvalid.

Test Plan:
- Read, ready=1, beats D0..D3=64'h0..0_1111×k (k=1..4) at addr 32'h1000_0044, returned 3 cycles after command → bmem_addr=32'h1000_0040; bmem_read high 1 cycle; valid_out 1 cycle after 4th beat; data_out={D3,D2,D1,D0}.
- Write, addr 32'h0000_2000, write_data=256'h{4×64'hAAAA..,BBBB..,CCCC..,DDDD..}, ready=1 → bmem_write high 4 consecutive cycles, wdata order: low slice first; valid_out at cycle 5; data_out=0.
- Write with bmem_ready low on beats 1 and 2 for 2 cycles each → each beat held stable while ready=0; exactly 4 accepted beats; valid_out at cycle 9.
- read_enable and write_enable both high, held through valid_out and COOL → exactly one write burst, no second transaction issued; IDLE reached one cycle after COOL.
- Stray bmem_rvalid in IDLE, and a beat with raddr≠latched addr in RD_WAIT → both ignored; line assembles only from the 4 matching beats.
- rst=0 during WR_BURST after 2 beats → next cycle all outputs 0 and state IDLE; a subsequent read completes correctly.
